// File: rtl/fixed_mac_resize.sv
// Signed fixed-point MAC: accumulates N full-precision products per frame, then emits one
// resized Q(WIO.WFO) result with overflow/underflow flags. Define ROUND_NEAREST_EN for round-half-up.
module fixed_mac_resize #(
  parameter int WI1 = 5,
  parameter int WF1 = 11,
  parameter int WI2 = 5,
  parameter int WF2 = 11,
  parameter int N   = 4,
  parameter int WIA = 12,
  parameter int WIO = 6,
  parameter int WFO = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WI1+WF1-1:0]   in_a,
  input  logic [WI2+WF2-1:0]   in_b,
  input  logic                 OF_saturation,
  input  logic                 UF_saturation,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIO+WFO-1:0]   out_data,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int WFP = WF1 + WF2;
  localparam int PW  = WI1 + WI2 + WFP;
  localparam int AW  = WIA + WFP;
  // One spare integer bit above the accumulator so rounding can never wrap the sign.
  localparam int XI  = (WIO > WIA + 1) ? WIO : WIA + 1;
  localparam int XW  = XI + WFP;
  localparam int OW  = WIO + WFO;
  localparam int DW  = WFP - WFO;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int RSH = (DW > 0) ? DW - 1 : 0;
  localparam int RINC = (DW > 0) ? 1 : 0;

  localparam logic [AW-1:0] DISC_MASK = (AW'(1) << DW) - AW'(1);
  localparam logic [OW-1:0] FRAC_ONES = (OW'(1) << WFO) - OW'(1);

  logic signed [AW-1:0] acc_q, acc_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 out_valid_q, out_valid_d;
  logic [OW-1:0]        out_data_q, out_data_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;

  logic signed [PW-1:0] a_ext, b_ext, prod;
  logic signed [AW-1:0] prod_ext, sum;
  logic signed [XW-1:0] s_ext, r_ext;
  logic [XW-WFP-WIO:0]  hi_bits;
  logic                 accept, frame_end;
  logic                 res_sign, res_ov, res_uf;
  logic [OW-1:0]        res_data;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign frame_end = accept && (count_q == CW'(N - 1));

  assign a_ext    = PW'($signed(in_a));
  assign b_ext    = PW'($signed(in_b));
  assign prod     = a_ext * b_ext;
  assign prod_ext = AW'(prod);
  assign sum      = acc_q + prod_ext;

  always_comb begin
    s_ext = XW'(sum);
`ifdef ROUND_NEAREST_EN
    r_ext = s_ext + (XW'(RINC) << RSH);
`else
    r_ext = s_ext;
`endif
    res_sign = r_ext[XW-1];
    hi_bits  = r_ext[XW-1:WFP+WIO-1];
    res_ov   = 1'b0;
    if (WIO < WIA) begin
      res_ov = !((&hi_bits) || !(|hi_bits));
    end
    // Underflow always reflects the unrounded sum.
    res_uf   = |(sum & DISC_MASK);
    res_data = {res_sign, r_ext[WFP+WIO-2:WFP-WFO]};
    if (res_ov && OF_saturation) begin
      res_data = res_sign ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end else if (res_uf && UF_saturation) begin
      res_data = res_data | FRAC_ONES;
    end
  end

  always_comb begin
    acc_d       = acc_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (frame_end) begin
      acc_d       = '0;
      count_d     = '0;
      out_valid_d = 1'b1;
      out_data_d  = res_data;
      overflow_d  = res_ov;
      underflow_d = res_uf;
    end else if (accept) begin
      acc_d   = sum;
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fixed_mac_resize.sv
// Bench for fixed_mac_resize: vector table of 4-pair frames plus backpressure and reset sequences.
module tb_fixed_mac_resize;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b;
  logic        OF_saturation, UF_saturation;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_data;
  logic        overflow, underflow;

  always #5 clk = ~clk;

  fixed_mac_resize #(
    .WI1(5), .WF1(11), .WI2(5), .WF2(11), .N(4), .WIA(12), .WIO(6), .WFO(11)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .OF_saturation(OF_saturation), .UF_saturation(UF_saturation),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .overflow(overflow), .underflow(underflow)
  );

  typedef struct {
    logic [16:0] data;
    logic        ov;
    logic        uf;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        of_sat;
    logic        uf_sat;
    logic [16:0] data;
    logic        ov;
    logic        uf;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   passed = 0;
  int   total  = 0;
  int   xfers  = 0;
  int   pushes = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
  endtask

  // Scoreboard side: every transfer is compared against the oldest expected result.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_result: got 0x%0h required none", out_data);
      end else begin
        mon_e = sb_q.pop_front();
        check("out_data", 32'(out_data), 32'(mon_e.data));
        check("overflow", 32'(overflow), 32'(mon_e.ov));
        check("underflow", 32'(underflow), 32'(mon_e.uf));
        $display("result 0x%05h ov=%0b uf=%0b", out_data, overflow, underflow);
      end
      xfers++;
    end
  end

  task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input bit last,
                           input bit push, input bit chk_lat, input exp_t e);
    int waited = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      $display("FAIL accept_timeout: got in_ready=0 required 1");
    end else begin
      if (last && chk_lat) check("valid_before_last", 32'(out_valid), 32'd0);
      if (last && push) begin
        sb_q.push_back(e);
        pushes++;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (last && chk_lat) check("valid_after_last", 32'(out_valid), 32'd1);
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input bit push,
                            input bit chk_lat, input exp_t e);
    for (int k = 0; k < 4; k++) send_pair(a, b, k == 3, push, chk_lat, e);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  vec_t vecs[12];
  exp_t e;
  int   xfer_base;

  initial begin
    vecs[0]  = '{16'h0800, 16'h1000, 1'b0, 1'b0, 17'h04000, 1'b0, 1'b0};
    vecs[1]  = '{16'h7800, 16'h7800, 1'b1, 1'b0, 17'h0FFFF, 1'b1, 1'b0};
    vecs[2]  = '{16'h7800, 16'h7800, 1'b0, 1'b0, 17'h02000, 1'b1, 1'b0};
    vecs[3]  = '{16'h0001, 16'h0001, 1'b0, 1'b0, 17'h00000, 1'b0, 1'b1};
    vecs[4]  = '{16'h0001, 16'h0001, 1'b0, 1'b1, 17'h007FF, 1'b0, 1'b1};
    vecs[5]  = '{16'hF800, 16'h0800, 1'b0, 1'b0, 17'h1E000, 1'b0, 1'b0};
    vecs[6]  = '{16'h8000, 16'h0A00, 1'b1, 1'b0, 17'h10000, 1'b1, 1'b0};
    vecs[7]  = '{16'h8000, 16'h0A00, 1'b0, 1'b0, 17'h18000, 1'b1, 1'b0};
    vecs[8]  = '{16'h0C00, 16'h0C00, 1'b0, 1'b0, 17'h04800, 1'b0, 1'b0};
`ifdef ROUND_NEAREST_EN
    vecs[9]  = '{16'h0001, 16'h0100, 1'b0, 1'b0, 17'h00001, 1'b0, 1'b1};
`else
    vecs[9]  = '{16'h0001, 16'h0100, 1'b0, 1'b0, 17'h00000, 1'b0, 1'b1};
`endif
    vecs[10] = '{16'h0800, 16'hF000, 1'b0, 1'b0, 17'h1C000, 1'b0, 1'b0};
    vecs[11] = '{16'h0001, 16'h0001, 1'b1, 1'b1, 17'h007FF, 1'b0, 1'b1};

    reset = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    OF_saturation = 1'b0;
    UF_saturation = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_underflow", 32'(underflow), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      OF_saturation = vecs[i].of_sat;
      UF_saturation = vecs[i].uf_sat;
      e = '{vecs[i].data, vecs[i].ov, vecs[i].uf};
      send_frame(vecs[i].a, vecs[i].b, 1'b1, 1'b1, e);
    end
    OF_saturation = 1'b0;
    UF_saturation = 1'b0;

    // Backpressure: result held while downstream stalls, no pair accepted meanwhile.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    e = '{17'h04000, 1'b0, 1'b0};
    send_frame(16'h0800, 16'h1000, 1'b1, 1'b0, e);
    xfer_base = xfers;
    in_a = 16'h0800;
    in_b = 16'h0800;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_hold_data", 32'(out_data), 32'h04000);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    e = '{17'h02000, 1'b0, 1'b0};
    send_frame(16'h0800, 16'h0800, 1'b1, 1'b0, e);
    repeat (3) @(posedge clk);
    #1;
    check("bp_transfers", 32'(xfers - xfer_base), 32'd2);

    // Reset drops a pending result.
    out_ready = 1'b0;
    e = '{17'h04000, 1'b0, 1'b0};
    send_frame(16'h0800, 16'h1000, 1'b0, 1'b0, e);
    check("pending_valid", 32'(out_valid), 32'd1);
    pulse_reset();
    check("drop_out_valid", 32'(out_valid), 32'd0);
    check("drop_out_data", 32'(out_data), 32'd0);
    out_ready = 1'b1;

    // Reset mid-frame discards the partial sum.
    xfer_base = xfers;
    for (int k = 0; k < 2; k++) send_pair(16'h0800, 16'h1000, 1'b0, 1'b0, 1'b0, e);
    pulse_reset();
    e = '{17'h02000, 1'b0, 1'b0};
    send_frame(16'h0800, 16'h0800, 1'b1, 1'b1, e);
    repeat (3) @(posedge clk);
    #1;
    check("midreset_transfers", 32'(xfers - xfer_base), 32'd1);

    for (int w = 0; w < 20 && sb_q.size() != 0; w++) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    check("total_transfers", 32'(xfers), 32'(pushes));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fixed_mac_resize.md
# fixed_mac_resize

Parametrised fixed-point multiply-accumulate with output resize. Accepts a stream of signed Q(WI1.WF1) × Q(WI2.WF2) operand pairs over a valid/ready handshake and accumulates N products at full fractional precision. It then emits one resized Q(WIO.WFO) result per frame, with per-result overflow and underflow flags and a backpressured output register. It sits in the Fixed_mul_accumulation datapath, replacing the standalone combinational resize stage.

## Interface
- WI1, 5, integer bits of operand A (sign included)
- WF1, 11, fractional bits of operand A
- WI2, 5, integer bits of operand B
- WF2, 11, fractional bits of operand B
- N, 4, products per frame; must be ≥1
- WIA, 12, accumulator integer bits; must be ≥ WI1+WI2
- WIO, 6, output integer bits; must be ≥2
- WFO, 11, output fractional bits; must be ≤ WF1+WF2
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept a pair
- in_a  input  WI1+WF1  signed operand A
- in_b  input  WI2+WF2  signed operand B
- OF_saturation  input  1  1: saturate on overflow; 0: wrap
- UF_saturation  input  1  1: force fraction to all ones on underflow
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  WIO+WFO  signed resized result
- overflow  output  1  result integer part did not fit, qualified by out_valid
- underflow  output  1  nonzero fraction bits discarded, qualified by out_valid

## Operation
- Product: full precision, WI1+WI2 integer and WFP = WF1+WF2 fractional bits. It is sign-extended into the accumulator of WIA+WFP bits. The accumulator wraps in two's complement, so size WIA to avoid overflow.
- Accept: an operand pair is accepted when in_valid && in_ready. The accepted product is added to acc, and count is incremented.
- Frame end: on the accept with count == N-1, the final sum S = acc + product is resized into the output register. acc and count are then cleared.
- Frame states: IDLE (count 0) -> ACCUM (0 < count < N) -> back to IDLE when the frame completes. The output register is EMPTY or FULL.
- Resize, overflow:
  - overflow = 1 when the bits of S above WFP+WIO-2 are not all equal to the sign bit.
  - If WIO ≥ WIA, overflow is always 0.
- Resize, integer part:
  - overflow && OF_saturation: the whole result saturates to the most positive value (0, then all ones) or the most negative value (1, then all zeros).
  - Otherwise: integer part is {sign, low WIO-1 integer bits}, or sign-extended when WIO > WIA.
- Resize, fraction:
  - underflow = |S[WFP-WFO-1:0] when WFO < WFP; otherwise 0.
  - Fraction is the top WFO fractional bits.
  - underflow && UF_saturation && !(overflow && OF_saturation): fraction is forced to all ones.
- in_ready = !out_valid || out_ready (combinational).

## Timing
- Reset values: out_valid 0, out_data 0, overflow 0, underflow 0, acc 0, count 0. in_ready reads 1 after reset.
- Latency: out_valid, out_data and the flags are registered. They assert on the edge after the N-th accept.
- Output hold: out_data and the flags stay stable while out_valid && !out_ready.
- Stall: while the output is full and out_ready is 0, in_ready is 0 and no pair is accepted. Partial accumulation of the next frame is allowed whenever in_ready is 1.
- Simultaneous events: when out_valid && out_ready coincides with a frame-end accept, the new result is loaded and out_valid stays 1. For N=1, this gives one result per cycle.
- Reset mid-frame: the partial sum is discarded, any pending output is dropped, and the next accepted pair starts a new frame.

## Configuration
- ROUND_NEAREST_EN defined:
  - Before the resize, 2^(WFP-WFO-1) is added to S in WIA+WFP+1 bits (round half up). The rounded value is then truncated.
  - Overflow is evaluated on the rounded value.
  - underflow still reports nonzero discarded bits of the unrounded S.
  - Applies only when WFO < WFP.
- ROUND_NEAREST_EN undefined: plain truncation toward −∞ as described in Operation.

## Test plan
- Defaults, ready tied high, 4× (a = 0x0800 (1.0), b = 0x1000 (2.0)) -> out_data 0x04000 (8.0), overflow 0, underflow 0, one cycle after the 4th accept.
- Wrap vs saturate: 4× (a = b = 0x7800 (15.0)), sum 900.0.
  - OF_saturation=1 -> out_data 0x0FFFF, overflow 1.
  - OF_saturation=0 -> out_data 0x02000 (4.0), overflow 1.
- Underflow and rounding: 4× (a = b = 0x0001), sum 2^-20.
  - UF_saturation=0 -> out_data 0x00000, underflow 1.
  - UF_saturation=1 -> out_data 0x007FF, underflow 1.
  - ROUND_NEAREST_EN with UF_saturation=0 -> out_data 0x00000.
- Negative sum: 4× (a = 0xF800 (−1.0), b = 0x0800 (1.0)) -> out_data 0x1E000 (−4.0), flags 0.
- Backpressure: out_ready=0 at frame end while in_valid stays high.
  - in_ready drops and out_data holds for 5 cycles.
  - out_ready=1 -> one transfer, and the next frame's result is correct.
- Reset mid-frame: reset after 2 accepts, then 4× (1.0 × 1.0) -> out_data 0x02000 (4.0); no result from the aborted frame appears.
